// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer with packet locking. Each channel has a one-entry
// output register, and a packet whose select is out of range is discarded and flagged on err.
//
// state | meaning
// IDLE  | next accepted beat is a first beat; target comes from in_sel
// BUSY  | mid-packet; target locked in r_ch until the last beat
// DROP  | mid-packet with an out-of-range select; beats are consumed and discarded
module stream_demux_n #(
   parameter int DATA_W = 8,
   parameter int N_OUT  = 4,
   parameter int SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_last,
   output logic [N_OUT-1:0]        out_valid,
   input  logic [N_OUT-1:0]        out_ready,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic [N_OUT-1:0]        out_last,
   output logic                    err
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP} state_t;

   localparam logic [SEL_W:0] LP_N_OUT = (SEL_W+1)'(N_OUT);

   state_t              r_state;
   state_t              w_nxt;
   logic [SEL_W-1:0]    r_ch;
   logic [N_OUT-1:0]    r_valid;
   logic [N_OUT-1:0]    r_last;
   logic [DATA_W-1:0]   r_data [N_OUT];
   logic                r_err;

   logic                w_sel_ok;
   logic [SEL_W-1:0]    w_target;
   logic [N_OUT-1:0]    w_free;
   logic                w_tgt_free;
   logic                w_acc;
   logic                w_route;
   logic                w_err_set;
   logic [N_OUT-1:0]    w_load;

   assign w_sel_ok = ({1'b0, in_sel} < LP_N_OUT);
   // A channel can take a beat this cycle if it is empty or is being drained right now.
   assign w_free   = ~r_valid | out_ready;

   always_comb begin
      w_target   = (r_state == S_BUSY) ? r_ch : in_sel;
      w_tgt_free = 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
         if (w_target == SEL_W'(i)) w_tgt_free = w_free[i];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ch    <= '0;
      end else begin
         r_state <= w_nxt;
         if (w_acc && r_state == S_IDLE && w_sel_ok && !in_last) r_ch <= in_sel;
      end
   end

   // Next-state logic
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:         if (w_acc && !in_last) w_nxt = w_sel_ok ? S_BUSY : S_DROP;
         S_BUSY, S_DROP: if (w_acc && in_last)  w_nxt = S_IDLE;
         default:        w_nxt = S_IDLE;
      endcase
   end

   // Output / handshake logic; in_ready never depends on in_valid
   always_comb begin
      in_ready = 1'b0;
      case (r_state)
         S_IDLE:  in_ready = w_sel_ok ? w_tgt_free : 1'b1;
         S_BUSY:  in_ready = w_tgt_free;
         S_DROP:  in_ready = 1'b1;
         default: in_ready = 1'b0;
      endcase
      if (rst) in_ready = 1'b0;
      w_acc     = in_valid & in_ready;
      w_route   = w_acc && ((r_state == S_BUSY) || (r_state == S_IDLE && w_sel_ok));
      w_err_set = w_acc && (r_state == S_IDLE) && !w_sel_ok;
      w_load    = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (w_route && w_target == SEL_W'(i)) w_load[i] = 1'b1;
      end
   end

   // Per-channel output registers; a refill wins over a simultaneous drain
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_last  <= '0;
         r_err   <= 1'b0;
         for (int i = 0; i < N_OUT; i++) r_data[i] <= '0;
      end else begin
         r_err <= w_err_set;
         for (int i = 0; i < N_OUT; i++) begin
            if (w_load[i]) begin
               r_valid[i] <= 1'b1;
               r_data[i]  <= in_data;
               r_last[i]  <= in_last;
            end else if (out_ready[i]) begin
               r_valid[i] <= 1'b0;
            end
         end
      end
   end

   assign out_valid = r_valid;
   assign out_last  = r_last;
   assign err       = r_err;

   for (genvar g = 0; g < N_OUT; g++) begin : g_out
      assign out_data[g*DATA_W +: DATA_W] = r_data[g];
   end

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: a 4-channel and a 3-channel instance share the input bus.
// Expected beats are queued per channel at acceptance and popped by a separate monitor.
module tb_stream_demux_n;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid4, in_valid3;
   logic [7:0]  in_data;
   logic [1:0]  in_sel;
   logic        in_last;
   logic        in_ready4, in_ready3;
   logic [3:0]  out_valid4, out_last4, out_ready4;
   logic [31:0] out_data4;
   logic [2:0]  out_valid3, out_last3, out_ready3;
   logic [23:0] out_data3;
   logic        err4, err3;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int err3_cnt = 0, err4_cnt = 0, err3_cyc = -1;
   bit any_valid3 = 1'b0;
   int pop_cyc4 [4];
   logic [8:0] q4 [4][$];
   logic [8:0] q3 [3][$];

   always #5 clk = ~clk;

   stream_demux_n #(.DATA_W(8), .N_OUT(4), .SEL_W(2)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
      .out_last(out_last4), .err(err4));

   stream_demux_n #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
      .out_last(out_last3), .err(err3));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one beat, wait for acceptance, queue the hand-computed expected beat.
   task automatic send(input bit use3, input logic [7:0] d, input logic [1:0] sel,
                       input logic last, input int exp_ch, output int waits, output int acc);
      bit ok = 1'b0;
      in_data = d; in_sel = sel; in_last = last;
      if (use3) in_valid3 = 1'b1; else in_valid4 = 1'b1;
      waits = 0;
      while (!ok && waits < 50) begin
         @(negedge clk);
         ok = use3 ? in_ready3 : in_ready4;
         if (!ok) waits++;
         @(posedge clk);
      end
      #1;
      acc = cyc;
      in_valid3 = 1'b0; in_valid4 = 1'b0;
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: beat %0h not accepted, required acceptance", d);
      end else if (exp_ch >= 0) begin
         if (use3) q3[exp_ch].push_back({last, d});
         else      q4[exp_ch].push_back({last, d});
      end
   endtask

   task automatic cycle_count();
      forever begin
         @(posedge clk);
         cyc++;
      end
   endtask

   task automatic monitor();
      logic [8:0] got, exp;
      forever begin
         @(negedge clk);
         if (err3) begin err3_cnt++; err3_cyc = cyc; end
         if (err4) err4_cnt++;
         if (|out_valid3) any_valid3 = 1'b1;
         if (!rst) begin
            for (int i = 0; i < 4; i++) begin
               if (out_valid4[i] && out_ready4[i]) begin
                  got = {out_last4[i], out_data4[i*8 +: 8]};
                  n_cmp++;
                  if (q4[i].size() == 0) begin
                     n_bad++;
                     $display("FAIL mon4_ch%0d: got %0h, required no beat", i, got);
                  end else begin
                     exp = q4[i].pop_front();
                     pop_cyc4[i] = cyc;
                     if (got !== exp) begin
                        n_bad++;
                        $display("FAIL mon4_ch%0d: got %0h required %0h", i, got, exp);
                     end
                  end
               end
            end
            for (int i = 0; i < 3; i++) begin
               if (out_valid3[i] && out_ready3[i]) begin
                  got = {out_last3[i], out_data3[i*8 +: 8]};
                  n_cmp++;
                  if (q3[i].size() == 0) begin
                     n_bad++;
                     $display("FAIL mon3_ch%0d: got %0h, required no beat", i, got);
                  end else begin
                     exp = q3[i].pop_front();
                     if (got !== exp) begin
                        n_bad++;
                        $display("FAIL mon3_ch%0d: got %0h required %0h", i, got, exp);
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic stall_checker();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k > 0) begin
            chk("bp_in_ready", 32'(in_ready4), 32'd0);
            chk("bp_valid1", 32'(out_valid4[1]), 32'd1);
            chk("bp_data1", 32'(out_data4[15:8]), 32'hB0);
         end
      end
      @(posedge clk);
      #1 out_ready4[1] = 1'b1;
   endtask

   task automatic bp_sender();
      int w, a;
      send(1'b0, 8'hB0, 2'd1, 1'b0, 1, w, a);
      chk("bp_first_wait", 32'(w), 32'd0);
      send(1'b0, 8'hB1, 2'd0, 1'b0, 1, w, a);
      chk("bp_second_wait", 32'(w), 32'd4);
      send(1'b0, 8'hB2, 2'd0, 1'b0, 1, w, a);
      send(1'b0, 8'hB3, 2'd0, 1'b1, 1, w, a);
      send(1'b0, 8'hC0, 2'd0, 1'b1, 0, w, a);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, a, a0, a1, a2;
      int acc [4];
      rst = 1'b1; in_valid4 = 1'b0; in_valid3 = 1'b0;
      in_data = '0; in_sel = '0; in_last = 1'b0;
      out_ready4 = 4'hF; out_ready3 = 3'h7;
      for (int i = 0; i < 4; i++) pop_cyc4[i] = -1;
      fork
         cycle_count();
         monitor();
      join_none

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready4), 32'd0);
      chk("rst_out_valid", 32'(out_valid4), 32'd0);
      chk("rst_out_data", out_data4, 32'd0);
      chk("rst_out_last", 32'(out_last4), 32'd0);
      chk("rst_err", 32'(err4), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // routing sweep
      for (int i = 0; i < 4; i++) begin
         send(1'b0, 8'(8'hA0 + i), 2'(i), 1'b1, i, w, acc[i]);
         chk("sweep_ready", 32'(w), 32'd0);
      end
      idle(2);
      for (int i = 0; i < 4; i++) chk("sweep_latency", 32'(pop_cyc4[i]), 32'(acc[i]));

      // packet lock: later selects ignored
      send(1'b0, 8'h11, 2'd2, 1'b0, 2, w, a);
      send(1'b0, 8'h12, 2'd0, 1'b0, 2, w, a);
      send(1'b0, 8'h13, 2'd3, 1'b1, 2, w, a);
      idle(2);
      chk("lock_drained", 32'(q4[2].size()), 32'd0);

      // backpressure on channel 1, then channel 0 traffic
      out_ready4[1] = 1'b0;
      fork
         stall_checker();
         bp_sender();
      join
      idle(3);
      chk("bp_ch1_drained", 32'(q4[1].size()), 32'd0);
      chk("bp_ch0_drained", 32'(q4[0].size()), 32'd0);

      // drop path on the 3-channel instance
      any_valid3 = 1'b0;
      send(1'b1, 8'hD0, 2'd3, 1'b0, -1, w, a0);
      chk("drop_ready0", 32'(w), 32'd0);
      send(1'b1, 8'hD1, 2'd2, 1'b1, -1, w, a1);
      chk("drop_ready1", 32'(w), 32'd0);
      idle(3);
      chk("drop_err_count", 32'(err3_cnt), 32'd1);
      chk("drop_err_cycle", 32'(err3_cyc), 32'(a0));
      chk("drop_no_valid", 32'(any_valid3), 32'd0);
      send(1'b1, 8'hE0, 2'd0, 1'b1, 0, w, a);
      idle(2);
      chk("drop_then_route", 32'(q3[0].size()), 32'd0);

      // back-to-back packet switch
      send(1'b0, 8'h51, 2'd0, 1'b0, 0, w, a0);
      send(1'b0, 8'h52, 2'd3, 1'b1, 0, w, a1);
      send(1'b0, 8'h61, 2'd3, 1'b1, 3, w, a2);
      chk("b2b_gap1", 32'(a1 - a0), 32'd1);
      chk("b2b_gap2", 32'(a2 - a1), 32'd1);
      idle(2);
      chk("b2b_ch3_drained", 32'(q4[3].size()), 32'd0);

      // reset mid-packet
      send(1'b0, 8'h71, 2'd1, 1'b0, 1, w, a);
      send(1'b0, 8'h72, 2'd1, 1'b0, 1, w, a);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready4), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid4", 32'(out_valid4), 32'd0);
      chk("midrst_valid3", 32'(out_valid3), 32'd0);
      chk("midrst_discarded", 32'(q4[1].size()), 32'd1);
      q4[1].delete();
      @(posedge clk);
      #1;
      send(1'b0, 8'h81, 2'd2, 1'b1, 2, w, a);
      idle(2);
      chk("midrst_route2", 32'(q4[2].size()), 32'd0);

      chk("err4_never", 32'(err4_cnt), 32'd0);
      for (int i = 0; i < 4; i++) chk("final_q4", 32'(q4[i].size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
